// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: sequencer state encoding and reset-cause codes shared by the
// reset sequencer and anything that decodes rst_cause_o.
package rst_seq_pkg;
    typedef enum logic [1:0] {HOLD, GAP, RUN, STRETCH} rst_seq_state_e;
    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;
endpackage

// File: rtl/rst_seq_wdt.sv
// rst_seq_wdt: watchdog counter; expire pulses when the count reaches its
// terminal value with no kick in the same cycle.
module rst_seq_wdt #(
    parameter int WDT_TIMEOUT = 2**20
) (
    input  logic wb_clk_o,
    input  logic sys_rst_i,
    input  logic en,
    input  logic kick,
    input  logic active,
    output logic expire
);
    localparam int WW = $clog2(WDT_TIMEOUT);

    logic [WW-1:0] cnt;

    // Not gated by active: the count is held at zero whenever active is low,
    // so expiry still wins over a same-cycle soft request that drops active.
    assign expire = en && !kick && cnt == WW'(WDT_TIMEOUT - 1);

    always_ff @(posedge wb_clk_o or posedge sys_rst_i) begin
        if (sys_rst_i)
            cnt <= '0;
        else
            cnt <= (!active || !en || kick || expire) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/rst_seq.sv
// rst_seq: releases domain resets one at a time after the Wishbone reset drops,
// and re-issues them on a software request or watchdog expiry.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_RST        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int STRETCH_CYCLES = 32,
    parameter int WDT_TIMEOUT    = 2**20
) (
    input  logic               wb_clk_o,
    input  logic               sys_rst_i,
    input  logic               wb_rst_i,
    input  logic               soft_rst_req_i,
    input  logic               wdt_en_i,
    input  logic               wdt_kick_i,
    output logic [NUM_RST-1:0] rst_o,
    output logic               seq_done_o,
    output logic [1:0]         rst_cause_o
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int SW = $clog2(STRETCH_CYCLES);
    localparam int IW = $clog2(NUM_RST);

    rst_seq_state_e     state, state_d;
    logic [GW-1:0]      gap_cnt, gap_cnt_d;
    logic [SW-1:0]      str_cnt, str_cnt_d;
    logic [IW-1:0]      idx, idx_d;
    logic [NUM_RST-1:0] rst_d;
    logic               done_d;
    logic [1:0]         cause_d;
    logic               expire;

    rst_seq_wdt #(.WDT_TIMEOUT(WDT_TIMEOUT)) u_wdt (
        .wb_clk_o (wb_clk_o),
        .sys_rst_i(sys_rst_i),
        .en       (wdt_en_i),
        .kick     (wdt_kick_i),
        .active   (state == RUN && !wb_rst_i && !soft_rst_req_i),
        .expire   (expire)
    );

    always_comb begin
        state_d   = state;
        gap_cnt_d = gap_cnt;
        str_cnt_d = str_cnt;
        idx_d     = idx;
        rst_d     = rst_o;
        done_d    = seq_done_o;
        cause_d   = rst_cause_o;
        if (wb_rst_i) begin
            state_d   = HOLD;
            gap_cnt_d = '0;
            str_cnt_d = '0;
            idx_d     = '0;
            rst_d     = '1;
            done_d    = 1'b0;
            cause_d   = CAUSE_EXT;
        end else begin
            case (state)
                HOLD: begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    idx_d     = '0;
                end
                GAP: begin
                    gap_cnt_d = gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        gap_cnt_d  = '0;
                        rst_d[idx] = 1'b0;
                        idx_d      = idx == IW'(NUM_RST - 1) ? idx : idx + 1'b1;
                        state_d    = idx == IW'(NUM_RST - 1) ? RUN : GAP;
                        done_d     = idx == IW'(NUM_RST - 1);
                    end
                end
                RUN: begin
                    if (expire || soft_rst_req_i) begin
                        state_d   = STRETCH;
                        str_cnt_d = '0;
                        rst_d     = '1;
                        done_d    = 1'b0;
                        cause_d   = expire ? CAUSE_WDT : CAUSE_SOFT;
                    end
                end
                STRETCH: begin
                    str_cnt_d = str_cnt + 1'b1;
                    if (str_cnt == SW'(STRETCH_CYCLES - 1)) begin
                        state_d   = GAP;
                        str_cnt_d = '0;
                        gap_cnt_d = '0;
                        idx_d     = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_o or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state       <= HOLD;
            gap_cnt     <= '0;
            str_cnt     <= '0;
            idx         <= '0;
            rst_o       <= '1;
            seq_done_o  <= 1'b0;
            rst_cause_o <= CAUSE_EXT;
        end else begin
            state       <= state_d;
            gap_cnt     <= gap_cnt_d;
            str_cnt     <= str_cnt_d;
            idx         <= idx_d;
            rst_o       <= rst_d;
            seq_done_o  <= done_d;
            rst_cause_o <= cause_d;
        end
    end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: checks rst_seq against a timestamp model (release edges, stretch
// windows and watchdog deadlines computed as edge counts).
module tb_rst_seq;
    localparam int NR  = 4;
    localparam int GAP = 16;
    localparam int STR = 32;
    localparam int WT  = 64;

    logic          wb_clk_o = 1'b0;
    logic          sys_rst_i = 1'b1;
    logic          wb_rst_i = 1'b1;
    logic          soft_rst_req_i = 1'b0;
    logic          wdt_en_i = 1'b0;
    logic          wdt_kick_i = 1'b0;
    logic [NR-1:0] rst_o;
    logic          seq_done_o;
    logic [1:0]    rst_cause_o;

    int errors = 0;
    int checks = 0;

    rst_seq #(
        .NUM_RST(NR), .GAP_CYCLES(GAP), .STRETCH_CYCLES(STR), .WDT_TIMEOUT(WT)
    ) dut (
        .wb_clk_o      (wb_clk_o),
        .sys_rst_i     (sys_rst_i),
        .wb_rst_i      (wb_rst_i),
        .soft_rst_req_i(soft_rst_req_i),
        .wdt_en_i      (wdt_en_i),
        .wdt_kick_i    (wdt_kick_i),
        .rst_o         (rst_o),
        .seq_done_o    (seq_done_o),
        .rst_cause_o   (rst_cause_o)
    );

    always #5 wb_clk_o = ~wb_clk_o;

    // Model: n counts edges; a release sequence starting at edge m_seq clears
    // bit i at m_seq+(i+1)*GAP; a stretch starting at m_str_at lasts STR edges;
    // the watchdog fires WT edges after its last restart m_ref.
    int         n = 0;
    bit         m_hold = 1'b1;
    bit         m_str = 1'b0;
    int         m_seq = 0;
    int         m_str_at = 0;
    int         m_ref = 0;
    logic [1:0] m_cause = 2'b00;

    task automatic model_step();
        n++;
        if (wb_rst_i) begin
            m_hold = 1'b1;
            m_str = 1'b0;
            m_cause = 2'b00;
        end else if (m_hold) begin
            m_hold = 1'b0;
            m_seq = n;
        end else if (m_str) begin
            if (n == m_str_at + STR) begin
                m_str = 1'b0;
                m_seq = n;
            end
        end else if (n > m_seq + NR * GAP) begin
            if (wdt_en_i && !wdt_kick_i && n - m_ref == WT) begin
                m_str = 1'b1;
                m_str_at = n;
                m_cause = 2'b10;
            end else if (soft_rst_req_i) begin
                m_str = 1'b1;
                m_str_at = n;
                m_cause = 2'b01;
            end else if (!wdt_en_i || wdt_kick_i) begin
                m_ref = n;
            end
        end
        if (!m_hold && !m_str && n == m_seq + NR * GAP) m_ref = n;
    endtask

    function automatic logic [NR+2:0] expected();
        logic [NR-1:0] r;
        for (int i = 0; i < NR; i++)
            r[i] = m_hold || m_str || n < m_seq + (i + 1) * GAP;
        return {r, !m_hold && !m_str && n >= m_seq + NR * GAP, m_cause};
    endfunction

    task automatic tick();
        @(posedge wb_clk_o);
        model_step();
        @(negedge wb_clk_o);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge wb_clk_o);
        checks++;
        if ({rst_o, seq_done_o, rst_cause_o} !== {4'b1111, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", {rst_o, seq_done_o, rst_cause_o}, {4'b1111, 1'b0, 2'b00});
        end
        sys_rst_i = 1'b0;
        repeat (10) begin
            tick();
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
        end
    endtask

    task automatic test_power_on();
        logic [NR-1:0] exp_r;
        wb_rst_i = 1'b0;
        for (int k = 0; k <= NR * GAP + 20; k++) begin
            tick();
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL power_on cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
            if (k > 0 && k % GAP == 0 && k <= NR * GAP) begin
                exp_r = 4'b1111 << (k / GAP);
                checks++;
                if ({rst_o, seq_done_o} !== {exp_r, k == NR * GAP}) begin
                    errors++;
                    $display("FAIL power_on_step k=%0d got=%b exp=%b", k, {rst_o, seq_done_o}, {exp_r, k == NR * GAP});
                end
            end
        end
    endtask

    task automatic wait_run(input string name);
        int k = 0;
        while (!seq_done_o && k < 300) begin
            tick();
            k++;
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL %s_wait cyc=%0d got=%b exp=%b", name, n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
        end
        checks++;
        if (!seq_done_o) begin
            errors++;
            $display("FAIL %s_timeout seq_done=%b exp=1", name, seq_done_o);
        end
    endtask

    task automatic test_soft();
        wdt_en_i = 1'b0;
        repeat ($urandom_range(1, 40)) begin
            wdt_kick_i = $urandom_range(0, 3) == 0;
            tick();
            wdt_kick_i = 1'b0;
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL soft_idle cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
        end
        soft_rst_req_i = 1'b1;
        tick();
        soft_rst_req_i = 1'b0;
        checks++;
        if ({rst_o, seq_done_o, rst_cause_o} !== {4'b1111, 1'b0, 2'b01}) begin
            errors++;
            $display("FAIL soft_enter got=%b exp=%b", {rst_o, seq_done_o, rst_cause_o}, {4'b1111, 1'b0, 2'b01});
        end
        for (int k = 1; k <= STR + NR * GAP + 5; k++) begin
            tick();
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL soft_seq cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
            if (k == STR + GAP - 1 || k == STR + GAP) begin
                checks++;
                if (rst_o !== (k == STR + GAP ? 4'b1110 : 4'b1111)) begin
                    errors++;
                    $display("FAIL soft_first_release k=%0d got=%b", k, rst_o);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        int k = 0;
        wdt_en_i = 1'b1;
        repeat (10) begin
            for (int j = 0; j < 50; j++) begin
                wdt_kick_i = j == 49;
                tick();
                wdt_kick_i = 1'b0;
                checks++;
                if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                    errors++;
                    $display("FAIL wdt_kicked cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
                end
            end
        end
        checks++;
        if (seq_done_o !== 1'b1) begin
            errors++;
            $display("FAIL wdt_no_reset seq_done=%b exp=1", seq_done_o);
        end
        while (seq_done_o && k < 200) begin
            tick();
            k++;
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL wdt_expiry cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
        end
        checks++;
        if (k !== WT || rst_cause_o !== 2'b10) begin
            errors++;
            $display("FAIL wdt_timing cycles=%0d cause=%b exp=%0d/10", k, rst_cause_o, WT);
        end
        wait_run("wdt");
    endtask

    task automatic test_simultaneous();
        wdt_en_i = 1'b1;
        for (int k = 0; k <= 2 * WT; k++) begin
            wdt_kick_i = k == 0 || k == WT;
            soft_rst_req_i = k == 2 * WT;
            tick();
            wdt_kick_i = 1'b0;
            soft_rst_req_i = 1'b0;
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL simul cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
            if (k == WT) begin
                checks++;
                if (seq_done_o !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_kick_wins seq_done=%b exp=1", seq_done_o);
                end
            end
        end
        checks++;
        if ({rst_o, rst_cause_o} !== {4'b1111, 2'b10}) begin
            errors++;
            $display("FAIL simul_wdt_wins got=%b exp=%b", {rst_o, rst_cause_o}, {4'b1111, 2'b10});
        end
        wait_run("simul");
    endtask

    task automatic test_mid_reset();
        int k = 0;
        wdt_en_i = 1'b0;
        soft_rst_req_i = 1'b1;
        tick();
        soft_rst_req_i = 1'b0;
        while (rst_o !== 4'b1100 && k < 200) begin
            tick();
            k++;
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL mid_wait cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
        end
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        checks++;
        if ({rst_o, seq_done_o, rst_cause_o} !== {4'b1111, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL mid_reassert got=%b exp=%b", {rst_o, seq_done_o, rst_cause_o}, {4'b1111, 1'b0, 2'b00});
        end
        for (int j = 0; j <= NR * GAP + 5; j++) begin
            tick();
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL mid_restart cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
            if (j == GAP) begin
                checks++;
                if (rst_o !== 4'b1110) begin
                    errors++;
                    $display("FAIL mid_bit0_first got=%b exp=1110", rst_o);
                end
            end
        end
    endtask

    task automatic test_ignored();
        soft_rst_req_i = 1'b1;
        tick();
        soft_rst_req_i = 1'b0;
        for (int k = 1; k <= STR + NR * GAP; k++) begin
            soft_rst_req_i = $urandom_range(0, 3) == 0;
            wdt_kick_i = $urandom_range(0, 3) == 0;
            tick();
            soft_rst_req_i = 1'b0;
            wdt_kick_i = 1'b0;
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL ignored cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
            if (k == STR + GAP) begin
                checks++;
                if (rst_o !== 4'b1110) begin
                    errors++;
                    $display("FAIL ignored_timing got=%b exp=1110", rst_o);
                end
            end
        end
        checks++;
        if ({seq_done_o, rst_cause_o} !== {1'b1, 2'b01}) begin
            errors++;
            $display("FAIL ignored_end got=%b exp=101", {seq_done_o, rst_cause_o});
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            wb_rst_i = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 99) == 0) wdt_en_i = ~wdt_en_i;
            wdt_kick_i = $urandom_range(0, 19) == 0;
            soft_rst_req_i = $urandom_range(0, 399) == 0;
            tick();
            checks++;
            if ({rst_o, seq_done_o, rst_cause_o} !== expected()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", n, {rst_o, seq_done_o, rst_cause_o}, expected());
            end
        end
        wb_rst_i = 1'b0;
        wdt_kick_i = 1'b0;
        soft_rst_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft();
        test_watchdog();
        test_simultaneous();
        test_mid_reset();
        test_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer fed by the synchronized Wishbone reset. It releases NUM_RST downstream domain resets (CPU, bus, peripherals, memory controller) one at a time, in a fixed order, with a fixed gap between each release. It also issues system resets on a software request or on watchdog expiry, and records the cause of the last reset. It sits between the global reset generation and every reset consumer in the SoC.

## Interface
- NUM_RST, 4: number of sequenced reset outputs; legal range 2..8.
- GAP_CYCLES, 16: cycles between successive releases; must be ≥1.
- STRETCH_CYCLES, 32: length of a soft/watchdog reset pulse; must be ≥2.
- WDT_TIMEOUT, 2**20: watchdog period in cycles; must be ≥2.

- wb_clk_o  input  1  clock (system Wishbone clock).
- sys_rst_i  input  1  reset, asynchronous, active-high.
- wb_rst_i  input  1  synchronized Wishbone reset, synchronous to wb_clk_o, active-high.
- soft_rst_req_i  input  1  single-cycle software reset request.
- wdt_en_i  input  1  watchdog enable; level.
- wdt_kick_i  input  1  single-cycle watchdog restart.
- rst_o  output  NUM_RST  active-high domain resets; bit 0 is released first.
- seq_done_o  output  1  high while all rst_o are released.
- rst_cause_o  output  2  00 external, 01 soft, 10 watchdog; 11 is never driven.

## Operation
- States: HOLD, GAP, RUN, STRETCH.
- On sys_rst_i: state HOLD, rst_o all ones, seq_done_o 0, rst_cause_o 00, all counters 0.
- **HOLD:** rst_o all ones. On the first edge that samples wb_rst_i=0, go to GAP with gap_cnt=0 and idx=0.
- **GAP:** gap_cnt increments each cycle.
  - When gap_cnt==GAP_CYCLES-1, clear rst_o[idx] and reset gap_cnt to 0.
  - If idx==NUM_RST-1, go to RUN and set seq_done_o. Otherwise increment idx.
  - Released bits stay low.
- **RUN:** watchdog counter wdt_cnt is active.
  - wdt_en_i=0 holds wdt_cnt at 0.
  - wdt_kick_i=1 clears wdt_cnt; otherwise wdt_cnt increments.
  - When wdt_cnt==WDT_TIMEOUT-1 and there is no kick that cycle, go to STRETCH with cause 10.
  - soft_rst_req_i=1 goes to STRETCH with cause 01.
- **STRETCH:** rst_o all ones, seq_done_o 0, str_cnt counts 0..STRETCH_CYCLES-1. Then go to GAP with idx=0 and gap_cnt=0.
- **Priority:** wb_rst_i=1 wins over everything in any state. It takes effect on the next edge: rst_o all ones, seq_done_o 0, cause 00, state HOLD.
  - Watchdog expiry wins over soft_rst_req_i in the same cycle.
  - A kick wins over expiry in the same cycle.
- soft_rst_req_i and wdt_kick_i are ignored outside RUN. wdt_cnt is 0 outside RUN.
- rst_cause_o changes only on entry to STRETCH or on wb_rst_i. It holds across the subsequent release sequence and RUN.
- Counter widths are $clog2 of their terminal value, with a minimum width of 1. Counters never wrap; they are reloaded explicitly.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Let E0 be the edge that samples wb_rst_i=0 in HOLD.
  - rst_o[i] falls at edge E0+(i+1)*GAP_CYCLES.
  - seq_done_o rises at the same edge as rst_o[NUM_RST-1] falls.
- Let T be the edge that samples a soft request or an expiry.
  - rst_o goes all ones at T.
  - rst_o[0] falls at T+STRETCH_CYCLES+GAP_CYCLES.
- Watchdog: with wdt_en_i held and no kicks, expiry occurs WDT_TIMEOUT cycles after RUN entry.
- wb_rst_i mid-sequence (GAP or STRETCH): all rst_o are reasserted at the next edge, the sequence restarts from HOLD, and no partial state is kept.

## Structure
- Package rst_seq_pkg holds:
  - the state enum typedef (rst_seq_state_e);
  - the cause constants CAUSE_EXT=2'b00, CAUSE_SOFT=2'b01, CAUSE_WDT=2'b10.
- One FSM and three counters in a single module.
- The watchdog is a natural sub-module, rst_seq_wdt. Inputs: en, kick, active. Output: expire pulse. Parameter: WDT_TIMEOUT.

## Test plan
- Power-on: sys_rst_i pulse, wb_rst_i low 10 cycles later, defaults → rst_o steps 1111→1110→1100→1000→0000 at 16-cycle spacing; seq_done_o rises with the last step; cause 00.
- Soft reset: in RUN, 1-cycle soft_rst_req_i → rst_o=1111 for 32 cycles, then the 4-step release; cause 01.
- Watchdog: WDT_TIMEOUT=64, wdt_en_i=1, kicks every 50 cycles for 500 cycles → no reset. Stop kicking → STRETCH exactly 64 cycles after the last kick; cause 10.
- Simultaneous events: kick and expiry in the same cycle → no reset. Soft request and expiry in the same cycle → cause 10.
- Mid-sequence reset: wb_rst_i asserted after rst_o=1100 → rst_o=1111 next edge, cause 00. Release wb_rst_i → full sequence restarts from bit 0.
- Ignored inputs: soft_rst_req_i and wdt_kick_i pulsed during GAP and STRETCH → no effect on state, timing, or cause.
